vt_char_writer: RTL
===================

# vt_char_writer

Character writer for the Apple 1 video terminal's recirculating 1024×8 character store. It sits in the recirculation path, between the store's serial output and its serial input. It accepts ASCII characters from the keyboard/PIA side through a valid/ready handshake and waits for the cursor slot to come round. At that slot it substitutes the new character for the recirculated one, then advances the cursor, scrolling and clearing as needed.

## Interface
- `COLS`, 40: characters per line
- `ROWS`, 24: lines per screen (`COLS*ROWS` ≤ 1024)
- `clk`, in, 1: single clock. All state changes occur on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `shift_ce`, in, 1: character-rate enable. It is high on the cycles when the store shifts one position.
- `so_in`, in, 8: character currently leaving the store, aligned with `pos`.
- `si_out`, out, 8: character to write back into the store. Combinational mux of `so_in` or the substituted value.
- `wr_data`, in, 7: ASCII character from the host.
- `wr_valid`, in, 1: `wr_data` is valid.
- `wr_ready`, out, 1: high only in IDLE. A transfer occurs when `wr_valid && wr_ready`.
- `clear_req`, in, 1: single-cycle request to blank the screen and home the cursor.
- `cursor_col`, out, 6: current column.
- `cursor_row`, out, 5: current row, 0 = top.
- `top_slot`, out, 10: physical slot holding row 0, column 0. The display reader uses it.
- `busy`, out, 1: equals `!wr_ready`.

## Operation
- `pos` counts store slots 0..1023. It increments mod 1024 on each `shift_ce`.
- Slots 0..959 form the screen ring. Slots 960..1023 are padding and are always rewritten with 0x20.
- Physical target slot: `(top_slot + cursor_row*COLS + cursor_col) mod 960`.
- A "hit" means `shift_ce` is high and `pos` equals the target.
- Character classes, decided at acceptance:
  - 0x0D (CR) is a newline.
  - 0x60..0x7E is folded to upper case by subtracting 0x20, then printed.
  - 0x20..0x5F is printed.
  - All other values are accepted and discarded, with no state change.
- States:
  - IDLE: `wr_ready`=1.
    - `clear_req` goes to CLEAR. It has priority over a same-cycle write, and that write is not accepted.
    - A printable transfer latches the character and goes to WRITE.
    - CR goes to NEWLINE. It makes no store access.
  - WRITE: on hit, `si_out` = latched character (bit 7 = 0).
    - `cursor_col`+1.
    - If this makes `cursor_col`==`COLS`, set `col`=0 and go to NEWLINE. Otherwise go to IDLE.
  - NEWLINE (one cycle): `cursor_col`=0.
    - If `cursor_row` < ROWS−1: `row`+1, then IDLE.
    - Otherwise `row` is unchanged; latch `scroll_base = top_slot`, `top_slot ← (top_slot+COLS) mod 960`, and go to SCROLL.
  - SCROLL: write 0x20 on the COLS consecutive hits at slots `scroll_base .. scroll_base+COLS−1` (mod 960), then IDLE. This blanks the new bottom line.
  - CLEAR: wait for `pos`==0 with `shift_ce`.
    - From then, write 0x20 on 1024 consecutive `shift_ce` cycles.
    - Then set `cursor_col`=0, `cursor_row`=0, `top_slot`=0, and go to IDLE.
- In any state, slots ≥ 960 get 0x20. Otherwise `si_out` = `so_in` unless substituting.
- `clear_req` outside IDLE is ignored. Software waits for `busy`=0.

## Timing
- Reset values:
  - `pos`=0, `cursor_col`=0, `cursor_row`=0, `top_slot`=0.
  - State = CLEAR, so `wr_ready`=0 and `busy`=1.
  - The store is fully blanked after 1024 `shift_ce` pulses following reset release.
- Handshake: accept on the edge where `wr_valid && wr_ready`. `wr_ready` drops on the next cycle.
- Write latency from acceptance to commit: 1..1024 `shift_ce` pulses. The cursor outputs update on the edge of the commit cycle.
- Scroll adds up to 1024+COLS pulses. Clear takes 1024..2047 pulses.
- Every counter is gated by `shift_ce`. With `shift_ce` held low, no slot is written and the FSM does not leave WRITE, SCROLL or CLEAR.
- `reset` asserted mid-operation: the edge takes reset values. Any partial write or scroll is abandoned and a full CLEAR restarts.
- `top_slot` wraps at 960: 920+40 → 0.

## Test plan
- **Reset clear:** assert `reset`, prefill the store with 0x41, run `shift_ce` every cycle. Required: `busy`=1 for ≤2047 pulses, then every slot reads 0x20, and the cursor is (0,0).
- **Print and case fold:** send 0x48 then 0x69. Required: slot 0 = 0x48, slot 1 = 0x49, cursor (col 2, row 0), and `wr_ready` stays low until each commit.
- **Line wrap and CR:**
  - 40 × 0x41 leaves the cursor at (0,1), with slots 0..39 = 0x41.
  - Then CR from (5,1) gives (0,2), with no slot changed.
- **Scroll:** fill to row 23 and print 40 chars. Required: `top_slot`=40, slots 0..39 = 0x20, cursor (0,23). Repeat to `top_slot`=920, then scroll once more to confirm the wrap to 0.
- **Ignored codes and clear priority:**
  - 0x07 and 0x7F are accepted with no slot or cursor change.
  - `clear_req` and `wr_valid` in the same cycle: CLEAR runs and the character is not accepted.
- **Mid-operation reset:** assert `reset` while in SCROLL. Required: outputs take reset values next edge, and a full clear completes.

Source files
------------

// File: rtl/vt_char_writer.sv
// rtl/vt_char_writer.sv - character writer in the recirculation path of the 1024x8 video store.
// Substitutes host characters at the cursor slot and handles wrap, scroll and clear.
module vt_char_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shift_ce,
  input  logic [7:0] so_in,
  output logic [7:0] si_out,
  input  logic [6:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       clear_req,
  output logic [5:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic [9:0] top_slot,
  output logic       busy
);

  localparam logic [10:0] SCREEN   = 11'(COLS * ROWS);
  localparam logic [10:0] COLS_W   = 11'(COLS);
  localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [7:0]  BLANK    = 8'h20;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_NEWLINE, S_SCROLL, S_CLEAR} state_t;

  state_t     state;
  logic [9:0] pos;
  logic [9:0] scroll_base;
  logic [5:0] scroll_cnt;
  logic [9:0] clr_cnt;
  logic       clearing;
  logic [6:0] ch;

  function automatic logic [9:0] ring_wrap(input logic [10:0] v);
    ring_wrap = (v >= SCREEN) ? 10'(v - SCREEN) : v[9:0];
  endfunction

  logic [10:0] line_off;
  logic [9:0]  target;
  logic [9:0]  scroll_slot;
  logic        hit, scroll_hit, clear_hit, padding;
  logic        is_cr, is_lower, is_print;
  logic [6:0]  folded;

  assign line_off    = 11'(cursor_row) * COLS_W + 11'(cursor_col);
  assign target      = ring_wrap({1'b0, top_slot} + line_off);
  assign scroll_slot = ring_wrap({1'b0, scroll_base} + 11'(scroll_cnt));
  assign hit         = shift_ce && (pos == target);
  assign scroll_hit  = shift_ce && (pos == scroll_slot);
  // The clear sweep starts on the pulse where slot 0 passes and then runs unconditionally.
  assign clear_hit   = shift_ce && (clearing || pos == 10'd0);
  assign padding     = {1'b0, pos} >= SCREEN;

  assign is_cr    = wr_data == 7'h0D;
  assign is_lower = (wr_data >= 7'h60) && (wr_data <= 7'h7E);
  assign is_print = (wr_data >= 7'h20) && (wr_data <= 7'h5F);
  assign folded   = is_lower ? (wr_data - 7'h20) : wr_data;

  assign wr_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_comb begin
    si_out = so_in;
    if (padding) begin
      si_out = BLANK;
    end else begin
      case (state)
        S_WRITE:  if (hit)        si_out = {1'b0, ch};
        S_SCROLL: if (scroll_hit) si_out = BLANK;
        S_CLEAR:  if (clear_hit)  si_out = BLANK;
        default:  si_out = so_in;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_CLEAR;
      pos         <= 10'd0;
      cursor_col  <= 6'd0;
      cursor_row  <= 5'd0;
      top_slot    <= 10'd0;
      scroll_base <= 10'd0;
      scroll_cnt  <= 6'd0;
      clr_cnt     <= 10'd0;
      clearing    <= 1'b0;
      ch          <= 7'd0;
    end else begin
      if (shift_ce) pos <= pos + 10'd1;
      case (state)
        S_IDLE: begin
          if (clear_req) begin
            clearing <= 1'b0;
            state    <= S_CLEAR;
          end else if (wr_valid) begin
            if (is_cr) begin
              state <= S_NEWLINE;
            end else if (is_print || is_lower) begin
              ch    <= folded;
              state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (hit) begin
            if (cursor_col == LAST_COL) begin
              cursor_col <= 6'd0;
              state      <= S_NEWLINE;
            end else begin
              cursor_col <= cursor_col + 6'd1;
              state      <= S_IDLE;
            end
          end
        end
        S_NEWLINE: begin
          cursor_col <= 6'd0;
          if (cursor_row < LAST_ROW) begin
            cursor_row <= cursor_row + 5'd1;
            state      <= S_IDLE;
          end else begin
            scroll_base <= top_slot;
            top_slot    <= ring_wrap({1'b0, top_slot} + COLS_W);
            scroll_cnt  <= 6'd0;
            state       <= S_SCROLL;
          end
        end
        S_SCROLL: begin
          if (scroll_hit) begin
            if (scroll_cnt == LAST_COL) state <= S_IDLE;
            else scroll_cnt <= scroll_cnt + 6'd1;
          end
        end
        S_CLEAR: begin
          if (clear_hit) begin
            if (clearing && clr_cnt == 10'h3FF) begin
              clearing   <= 1'b0;
              cursor_col <= 6'd0;
              cursor_row <= 5'd0;
              top_slot   <= 10'd0;
              state      <= S_IDLE;
            end else begin
              clearing <= 1'b1;
              clr_cnt  <= clearing ? clr_cnt + 10'd1 : 10'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
